// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : 640x480@60 raster constants, control-bundle type and a
//                window-decode helper shared by the VGA timing generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int VGA_CLK_DIV  = 4;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam bit VGA_HS_POL   = 1'b0;
    localparam bit VGA_VS_POL   = 1'b0;

    localparam int VGA_CNT_W    = 10;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic line_start;
        logic frame_start;
    } vga_ctl_t;

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(input int unsigned pos,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_en_div.sv
// ============================================================================
//  Module      : clk_en_div
//  Description : Free-running modulo-DIV counter; tick is high during the
//                last clk of each DIV-clk period.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // DIV=1 still needs a 1-bit counter; it simply stays at zero.
    localparam int              c_DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_DW-1:0] c_LAST = c_DW'(DIV - 1);

    logic [c_DW-1:0] div_cnt_q;
    logic [c_DW-1:0] div_cnt_d;

    always_comb begin
        tick      = (div_cnt_q == c_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + c_DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster timing generator: pixel-rate enable, h/v counters,
//                registered sync, active-video and line/frame strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = VGA_HS_POL,
    parameter bit VS_POL   = VGA_VS_POL,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HS_LO   = H_ACTIVE + H_FP;
    localparam int c_HS_HI   = c_HS_LO + H_SYNC - 1;
    localparam int c_VS_LO   = V_ACTIVE + V_FP;
    localparam int c_VS_HI   = c_VS_LO + V_SYNC - 1;

    localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACTIVE = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACTIVE = CNT_W'(V_ACTIVE);

    // Reset parks the raster on the last back-porch pixel so the first
    // pixel strobe lands cleanly on (0,0).
    localparam vga_ctl_t c_CTL_RST = '{
        hsync:       ~HS_POL,
        vsync:       ~VS_POL,
        active:      1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    logic             tick;
    logic             pix_ce_q,  pix_ce_d;
    logic [CNT_W-1:0] hcount_q,  hcount_d;
    logic [CNT_W-1:0] vcount_q,  vcount_d;
    vga_ctl_t         ctl_q,     ctl_d;

    logic [CNT_W-1:0] hcount_nxt;
    logic [CNT_W-1:0] vcount_nxt;
    vga_ctl_t         ctl_nxt;

    clk_en_div #(
        .DIV (CLK_DIV)
    ) u_clk_en_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        hcount_nxt = hcount_q + CNT_W'(1);
        vcount_nxt = vcount_q;
        if (hcount_q == c_H_LAST) begin
            hcount_nxt = '0;
            vcount_nxt = (vcount_q == c_V_LAST) ? '0 : vcount_q + CNT_W'(1);
        end
    end

    // Decode from the next position so every output flips on the same edge.
    always_comb begin
        ctl_nxt.hsync       = in_window(32'(hcount_nxt), c_HS_LO, c_HS_HI) ? HS_POL : ~HS_POL;
        ctl_nxt.vsync       = in_window(32'(vcount_nxt), c_VS_LO, c_VS_HI) ? VS_POL : ~VS_POL;
        ctl_nxt.active      = (hcount_nxt < c_H_ACTIVE) && (vcount_nxt < c_V_ACTIVE);
        ctl_nxt.line_start  = (hcount_nxt == '0);
        ctl_nxt.frame_start = (hcount_nxt == '0) && (vcount_nxt == '0);
    end

    always_comb begin
        pix_ce_d = tick;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        ctl_d    = ctl_q;
        ctl_d.line_start  = 1'b0;
        ctl_d.frame_start = 1'b0;
        if (tick) begin
            hcount_d = hcount_nxt;
            vcount_d = vcount_nxt;
            ctl_d    = ctl_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_ce_q <= 1'b0;
            hcount_q <= c_H_LAST;
            vcount_q <= c_V_LAST;
            ctl_q    <= c_CTL_RST;
        end else begin
            pix_ce_q <= pix_ce_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            ctl_q    <= ctl_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = ctl_q.hsync;
    assign vsync       = ctl_q.vsync;
    assign active      = ctl_q.active;
    assign line_start  = ctl_q.line_start;
    assign frame_start = ctl_q.frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed bench for vga_timing_gen: default 640x480 build and
//                a reduced 14x7 build with CLK_DIV=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    logic clk;
    logic rst_a;
    logic rst_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_pix_ce, a_hsync, a_vsync, a_active, a_line_start, a_frame_start;
    logic [9:0] a_hcount, a_vcount;
    logic       b_pix_ce, b_hsync, b_vsync, b_active, b_line_start, b_frame_start;
    logic [3:0] b_hcount, b_vcount;

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .pix_ce      (a_pix_ce),
        .hcount      (a_hcount),
        .vcount      (a_vcount),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .active      (a_active),
        .line_start  (a_line_start),
        .frame_start (a_frame_start)
    );

    vga_timing_gen #(
        .CLK_DIV  (1),
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b0), .VS_POL (1'b0),
        .CNT_W    (4)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .pix_ce      (b_pix_ce),
        .hcount      (b_hcount),
        .vcount      (b_vcount),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .active      (b_active),
        .line_start  (b_line_start),
        .frame_start (b_frame_start)
    );

    // Selected-DUT view so one set of tasks serves both builds.
    logic        sel;
    logic [31:0] cur_h, cur_v;
    logic        cur_ce, cur_hs, cur_vs, cur_act, cur_ls, cur_fs;

    always_comb begin
        if (sel) begin
            cur_h = 32'(b_hcount);  cur_v = 32'(b_vcount);
            cur_ce = b_pix_ce;      cur_hs = b_hsync;  cur_vs = b_vsync;
            cur_act = b_active;     cur_ls = b_line_start; cur_fs = b_frame_start;
        end else begin
            cur_h = 32'(a_hcount);  cur_v = 32'(a_vcount);
            cur_ce = a_pix_ce;      cur_hs = a_hsync;  cur_vs = a_vsync;
            cur_act = a_active;     cur_ls = a_line_start; cur_fs = a_frame_start;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cfg_div, cfg_ht, cfg_vt, cfg_ha, cfg_va, cfg_hs_lo, cfg_hs_hi, cfg_vs_lo, cfg_vs_hi;

    task automatic use_dut(input logic s);
        sel = s;
        if (s) begin
            cfg_div = 1; cfg_ht = 14;  cfg_vt = 7;   cfg_ha = 8;   cfg_va = 4;
            cfg_hs_lo = 10;  cfg_hs_hi = 11;  cfg_vs_lo = 5;   cfg_vs_hi = 5;
        end else begin
            cfg_div = 4; cfg_ht = 800; cfg_vt = 525; cfg_ha = 640; cfg_va = 480;
            cfg_hs_lo = 656; cfg_hs_hi = 751; cfg_vs_lo = 490; cfg_vs_hi = 491;
        end
    endtask

    // Independent raster model and per-window statistics.
    int m_phase, m_h, m_v;
    int ce_cnt, ls_cnt, fs_cnt, hs_low, vs_low, act_pix, vwrap;
    int err_ce, err_pos, err_dec, pre_err;

    task automatic run_window(input int n);
        logic exp_ce, exp_hs, exp_vs, exp_act, exp_ls, exp_fs;
        logic [31:0] prev_v;
        ce_cnt = 0; ls_cnt = 0; fs_cnt = 0; hs_low = 0; vs_low = 0; act_pix = 0; vwrap = 0;
        err_ce = 0; err_pos = 0; err_dec = 0;
        prev_v = cur_v;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            m_phase = (m_phase + 1) % cfg_div;
            exp_ce  = (m_phase == 0);
            if (exp_ce) begin
                if (m_h == cfg_ht - 1) begin
                    m_h = 0;
                    m_v = (m_v == cfg_vt - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
            exp_hs  = !(m_h >= cfg_hs_lo && m_h <= cfg_hs_hi);
            exp_vs  = !(m_v >= cfg_vs_lo && m_v <= cfg_vs_hi);
            exp_act = (m_h < cfg_ha) && (m_v < cfg_va);
            exp_ls  = exp_ce && (m_h == 0);
            exp_fs  = exp_ls && (m_v == 0);
            if (cur_ce !== exp_ce) err_ce++;
            if (cur_h !== 32'(m_h) || cur_v !== 32'(m_v)) err_pos++;
            if ({cur_hs, cur_vs, cur_act, cur_ls, cur_fs} !== {exp_hs, exp_vs, exp_act, exp_ls, exp_fs})
                err_dec++;
            ce_cnt  += cur_ce ? 1 : 0;
            ls_cnt  += cur_ls ? 1 : 0;
            fs_cnt  += cur_fs ? 1 : 0;
            hs_low  += cur_hs ? 0 : 1;
            vs_low  += cur_vs ? 0 : 1;
            act_pix += (cur_ce && cur_act) ? 1 : 0;
            if (prev_v == 32'(cfg_vt - 1) && cur_v == 32'd0) vwrap++;
            prev_v = cur_v;
        end
    endtask

    // Counts clk edges after reset release until the first pix_ce; 0 if none.
    task automatic wait_first_ce(output int n);
        logic [31:0] h0, v0;
        n = 0; pre_err = 0;
        h0 = cur_h; v0 = cur_v;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (cur_ce) begin
                n = i;
                break;
            end
            if (cur_h !== h0 || cur_v !== v0 || cur_ls || cur_fs) pre_err++;
        end
        m_phase = 0; m_h = 0; m_v = 0;
    endtask

    task automatic check_reset(input string tag, input int hl, input int vl);
        check({tag, "_pix_ce"}, 32'(cur_ce), 0);
        check({tag, "_hcount"}, cur_h, 32'(hl));
        check({tag, "_vcount"}, cur_v, 32'(vl));
        check({tag, "_hsync"},  32'(cur_hs), 1);
        check({tag, "_vsync"},  32'(cur_vs), 1);
        check({tag, "_active"}, 32'(cur_act), 0);
        check({tag, "_strobes"}, 32'({cur_ls, cur_fs}), 0);
    endtask

    task automatic check_first_pixel(input string tag, input int lat, input int exp_lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_pre_hold"}, 32'(pre_err), 0);
        check({tag, "_h0"}, cur_h, 0);
        check({tag, "_v0"}, cur_v, 0);
        check({tag, "_active"}, 32'(cur_act), 1);
        check({tag, "_frame_start"}, 32'(cur_fs), 1);
        check({tag, "_line_start"}, 32'(cur_ls), 1);
        check({tag, "_hsync"}, 32'(cur_hs), 1);
    endtask

    int lat;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        use_dut(1'b0);

        // Default build: reset state and first pixel
        repeat (20) @(posedge clk);
        #1;
        check_reset("a_rst", 799, 524);
        @(negedge clk) rst_a = 1'b0;
        wait_first_ce(lat);
        check_first_pixel("a_start", lat, 4);

        // 100 pixels of free run
        run_window(400);
        check("a_run_ce_count", 32'(ce_cnt), 100);
        check("a_run_ce_err", 32'(err_ce), 0);
        check("a_run_pos_err", 32'(err_pos), 0);
        check("a_run_hcount", cur_h, 100);

        // One full line
        run_window(3200);
        check("a_line_ce_count", 32'(ce_cnt), 800);
        check("a_line_hs_low_clk", 32'(hs_low), 384);
        check("a_line_active_pix", 32'(act_pix), 640);
        check("a_line_ls_count", 32'(ls_cnt), 1);
        check("a_line_fs_count", 32'(fs_cnt), 0);
        check("a_line_pos_err", 32'(err_pos), 0);
        check("a_line_dec_err", 32'(err_dec), 0);

        // Mid-frame reset pulse at (300,1)
        run_window(800);
        check("a_pre_pulse_h", cur_h, 300);
        check("a_pre_pulse_v", cur_v, 1);
        @(negedge clk) rst_a = 1'b1;
        @(posedge clk); #1;
        check_reset("a_pulse", 799, 524);
        @(negedge clk) rst_a = 1'b0;
        wait_first_ce(lat);
        check_first_pixel("a_restart", lat, 4);

        // Reduced build: CLK_DIV=1, 14x7 raster
        use_dut(1'b1);
        @(negedge clk);
        check_reset("b_rst", 13, 6);
        rst_b = 1'b0;
        wait_first_ce(lat);
        check_first_pixel("b_start", lat, 1);

        run_window(98);
        check("b_frame_ce_count", 32'(ce_cnt), 98);
        check("b_frame_ls_count", 32'(ls_cnt), 7);
        check("b_frame_fs_count", 32'(fs_cnt), 1);
        check("b_frame_hs_low", 32'(hs_low), 14);
        check("b_frame_vs_low", 32'(vs_low), 14);
        check("b_frame_active", 32'(act_pix), 32);
        check("b_frame_vwrap", 32'(vwrap), 1);
        check("b_frame_pos_err", 32'(err_pos), 0);
        check("b_frame_dec_err", 32'(err_dec), 0);
        check("b_frame_end_h", cur_h, 0);
        check("b_frame_end_v", cur_v, 0);

        run_window(40);
        check("b_mid_dec_err", 32'(err_dec), 0);
        @(negedge clk) rst_b = 1'b1;
        @(posedge clk); #1;
        check_reset("b_pulse", 13, 6);
        @(negedge clk) rst_b = 1'b0;
        wait_first_ce(lat);
        check_first_pixel("b_restart", lat, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
